// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor computing A - B - Bin, one bit per clock, LSB first.
//   Results are registered and only change when an operation completes.
//
// Ports
//   clk    system clock (rising edge)
//   rst    synchronous active-high reset
//   start  begin a subtraction (accepted in IDLE or DONE)
//   A, B   minuend / subtrahend, latched when start is accepted
//   Bin    borrow-in, latched when start is accepted
//   Diff   registered difference, modulo 2^WIDTH
//   Bout   registered borrow-out (unsigned A < B + Bin)
//   V      registered two's-complement overflow flag
//   busy   high while bits are being processed
//   done   one-cycle pulse marking valid Diff/Bout/V
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             V,
  output logic             busy,
  output logic             done
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] acc;
  logic [IW-1:0]    idx;
  logic             br;

  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_next;
  logic             last;
  logic [WIDTH-1:0] diff_full;

  always_comb begin
    a_bit     = a_reg[idx];
    b_bit     = b_reg[idx];
    d_bit     = a_bit ^ b_bit ^ br;
    br_next   = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
    last      = (idx == IW'(WIDTH - 1));
    // Final result: accumulated low bits plus the MSB produced this cycle,
    // so Diff is written once and never exposes a partial value.
    diff_full = acc;
    diff_full[WIDTH-1] = d_bit;
  end

  always_comb begin
    busy = (state == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_reg <= '0;
      b_reg <= '0;
      acc   <= '0;
      idx   <= '0;
      br    <= 1'b0;
      Diff  <= '0;
      Bout  <= 1'b0;
      V     <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            a_reg <= A;
            b_reg <= B;
            br    <= Bin;
            idx   <= '0;
            acc   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc[idx] <= d_bit;
          br       <= br_next;
          idx      <= idx + IW'(1);
          if (last) begin
            Diff  <= diff_full;
            Bout  <= br_next;
            V     <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) & (a_reg[WIDTH-1] ^ d_bit);
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Directed table of WIDTH=4 vectors, hand-written multi-cycle sequences
//   (ignored start, mid-run reset, held start) and random WIDTH=4/8 checks
//   against an integer reference model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start4, start8;
  logic [3:0] A4, B4;
  logic [7:0] A8, B8;
  logic       Bin4, Bin8;
  logic [3:0] Diff4;
  logic [7:0] Diff8;
  logic       Bout4, V4, busy4, done4;
  logic       Bout8, V8, busy8, done8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .A(A4), .B(B4), .Bin(Bin4),
    .Diff(Diff4), .Bout(Bout4), .V(V4), .busy(busy4), .done(done4)
  );

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .A(A8), .B(B8), .Bin(Bin8),
    .Diff(Diff8), .Bout(Bout8), .V(V8), .busy(busy8), .done(done8)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       bin;
    logic [3:0] diff;
    logic       bout;
    logic       v;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full operation on the 4-bit instance with fixed-latency checks;
  // operands are scrambled while busy to confirm they were latched.
  task automatic run_op4(input string tag, input logic [3:0] a, input logic [3:0] b,
                         input logic bin, input logic [3:0] ediff,
                         input logic ebout, input logic ev);
    @(negedge clk);
    A4 = a; B4 = b; Bin4 = bin; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0; A4 = ~a; B4 = ~b; Bin4 = ~bin;
    check({tag, " busy c1"}, busy4, 1);
    check({tag, " done c1"}, done4, 0);
    for (int i = 2; i <= 4; i++) begin
      @(posedge clk); #1;
      check($sformatf("%s busy c%0d", tag, i), busy4, 1);
      check($sformatf("%s done c%0d", tag, i), done4, 0);
    end
    @(posedge clk); #1;
    check({tag, " done"}, done4, 1);
    check({tag, " busy end"}, busy4, 0);
    check({tag, " Diff"}, Diff4, ediff);
    check({tag, " Bout"}, Bout4, ebout);
    check({tag, " V"}, V4, ev);
    @(posedge clk); #1;
    check({tag, " done pulse"}, done4, 0);
    check({tag, " Diff hold"}, Diff4, ediff);
  endtask

  initial begin
    logic [3:0] ra, rb;
    logic [7:0] qa, qb;
    logic       rbin;
    int         r, sr, cyc, npulse;

    tbl[0] = '{4'b0011, 4'b0101, 1'b0, 4'b1110, 1'b1, 1'b0};
    tbl[1] = '{4'b0110, 4'b0011, 1'b1, 4'b0010, 1'b0, 1'b0};
    tbl[2] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 1'b1, 1'b0};
    tbl[3] = '{4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1};
    tbl[4] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[5] = '{4'b0111, 4'b1000, 1'b0, 4'b1111, 1'b1, 1'b1};
    tbl[6] = '{4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0};
    tbl[7] = '{4'b0101, 4'b0101, 1'b0, 4'b0000, 1'b0, 1'b0};
    tbl[8] = '{4'b1000, 4'b0000, 1'b1, 4'b0111, 1'b0, 1'b1};
    tbl[9] = '{4'b1111, 4'b0000, 1'b0, 4'b1111, 1'b0, 1'b0};

    // Reset with start asserted: reset must win.
    rst = 1'b1; start4 = 1'b1; start8 = 1'b1;
    A4 = 4'hF; B4 = 4'h1; Bin4 = 1'b0; A8 = '0; B8 = '0; Bin8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", busy4, 0);
    check("rst done", done4, 0);
    check("rst Diff", Diff4, 0);
    check("rst Bout", Bout4, 0);
    check("rst V", V4, 0);
    check("rst busy8", busy8, 0);
    check("rst Diff8", Diff8, 0);
    rst = 1'b0; start4 = 1'b0; start8 = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op4($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].bin,
              tbl[i].diff, tbl[i].bout, tbl[i].v);

    // start while busy is ignored
    @(negedge clk);
    A4 = 4'b1111; B4 = 4'b0001; Bin4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    @(posedge clk); #1;
    A4 = 4'b0000; B4 = 4'b0001; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0; A4 = 4'b0101; B4 = 4'b1010;
    check("ign busy c3", busy4, 1);
    @(posedge clk); #1;
    check("ign busy c4", busy4, 1);
    @(posedge clk); #1;
    check("ign done", done4, 1);
    check("ign Diff", Diff4, 4'b1110);
    check("ign Bout", Bout4, 0);
    check("ign V", V4, 0);
    @(posedge clk); #1;
    check("ign idle busy", busy4, 0);
    check("ign idle done", done4, 0);

    // reset in the second RUN cycle aborts with no done pulse
    @(negedge clk);
    A4 = 4'b0011; B4 = 4'b0101; Bin4 = 1'b0; start4 = 1'b1;
    @(posedge clk); #1; start4 = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    check("abort busy", busy4, 0);
    check("abort done", done4, 0);
    check("abort Diff", Diff4, 0);
    check("abort Bout", Bout4, 0);
    check("abort V", V4, 0);
    npulse = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done4 === 1'b1 || busy4 === 1'b1) npulse++;
    end
    check("abort no done", npulse, 0);
    run_op4("post abort", 4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1);

    // start accepted in the first cycle after reset releases
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    run_op4("after rst", 4'b0110, 4'b0011, 1'b1, 4'b0010, 1'b0, 1'b0);

    // start held high: back-to-back operations every WIDTH+1 cycles
    @(negedge clk);
    A4 = 4'b0110; B4 = 4'b0011; Bin4 = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    for (int p = 0; p < 3; p++) begin
      cyc = 0;
      do begin
        @(posedge clk); #1;
        cyc++;
      end while (done4 !== 1'b1 && cyc < 12);
      check($sformatf("held period%0d", p), cyc, (p == 0) ? 4 : 5);
      check($sformatf("held Diff%0d", p), Diff4, 4'b0010);
      check($sformatf("held Bout%0d", p), Bout4, 0);
    end
    start4 = 1'b0;
    repeat (6) @(posedge clk);

    // random WIDTH=4 against integer model
    for (int k = 0; k < 20; k++) begin
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rbin = 1'($urandom_range(0, 1));
      r  = int'(ra) - int'(rb) - int'(rbin);
      sr = int'($signed(ra)) - int'($signed(rb)) - int'(rbin);
      run_op4($sformatf("rnd4_%0d", k), ra, rb, rbin, r[3:0],
              (r < 0), (sr < -8 || sr > 7));
    end

    // random WIDTH=8 against integer model
    for (int k = 0; k < 20; k++) begin
      qa = 8'($urandom_range(0, 255));
      qb = 8'($urandom_range(0, 255));
      rbin = 1'($urandom_range(0, 1));
      r  = int'(qa) - int'(qb) - int'(rbin);
      sr = int'($signed(qa)) - int'($signed(qb)) - int'(rbin);
      @(negedge clk);
      A8 = qa; B8 = qb; Bin8 = rbin; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0; A8 = ~qa; B8 = ~qb; Bin8 = ~rbin;
      cyc = 1;
      while (done8 !== 1'b1 && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      check($sformatf("rnd8_%0d latency", k), cyc, 9);
      check($sformatf("rnd8_%0d Diff", k), Diff8, r[7:0]);
      check($sformatf("rnd8_%0d Bout", k), Bout8, (r < 0));
      check($sformatf("rnd8_%0d V", k), V8, (sr < -128 || sr > 127));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
